// File: rtl/cp_pkg_1506.sv
// cp_pkg_1506: shared encodings for the cryptoprocessor sequencer.
// Holds instruction opcodes, command width and the sequencer state type.
package cp_pkg_1506;

    localparam int CMD_W = 24;
    localparam int INS_W = 3;

    typedef enum logic [INS_W-1:0] {
        INS_NOP  = 3'd0,
        INS_ADD  = 3'd1,
        INS_SUB  = 3'd2,
        INS_MUL  = 3'd3,
        INS_RED  = 3'd4,
        INS_HALT = 3'd7
    } ins_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_READOUT,
        S_FIN
    } state_e;

    function automatic logic is_halt(input logic [CMD_W-1:0] word);
        return word[CMD_W-1 -: INS_W] == INS_HALT;
    endfunction

endpackage

// File: rtl/cp_watchdog.sv
// cp_watchdog: cycle counter that flags when an instruction has waited too long.
// Expires on the TIMEOUT-th consecutive enabled cycle since the last clear.
module cp_watchdog #(
    parameter int TIMEOUT = 4095
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (clear)
            r_cnt <= '0;
        else if (enable)
            r_cnt <= r_cnt + 1'b1;
    end

    assign expire = enable && (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/cp_sequencer_1506.sv
// cp_sequencer_1506: loads operands, steps a ROM program through the cryptoprocessor,
// then reads results back; guards each instruction with a watchdog.
module cp_sequencer_1506
    import cp_pkg_1506::*;
#(
    parameter int PC_W    = 10,
    parameter int N_LOAD  = 8,
    parameter int N_OUT   = 2,
    parameter int TIMEOUT = 4095
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic [PC_W-1:0]  prog_addr,
    input  logic [CMD_W-1:0] prog_data,
    output logic [CMD_W-1:0] command_cp,
    output logic             ins_in,
    output logic             data_en,
    output logic             get_output,
    input  logic             cp_done,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int CNT_W = $clog2((N_LOAD > N_OUT ? N_LOAD : N_OUT) + 1);
    localparam logic [PC_W-1:0] PC_LAST = '1;

    state_e             r_state, w_next;
    logic [PC_W-1:0]    r_pc;
    logic [CNT_W-1:0]   r_cnt;
    logic [CMD_W-1:0]   r_cmd;
    logic               r_done, r_error;
    logic               w_halt, w_expire, w_pc_last, w_load_acc, w_load_last, w_out_last;
    logic               w_issue, w_wait_done, w_fault;
    logic [CMD_W-1:0]   w_cnt_cmd;

    cp_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (r_state != S_WAIT),
        .enable (r_state == S_WAIT),
        .expire (w_expire)
    );

    always_comb begin
        w_halt      = is_halt(prog_data);
        w_pc_last   = r_pc == PC_LAST;
        w_load_acc  = (r_state == S_LOAD) && in_valid;
        w_load_last = r_cnt == CNT_W'(N_LOAD - 1);
        w_out_last  = r_cnt == CNT_W'(N_OUT - 1);
        w_issue     = (r_state == S_ISSUE) && !w_halt;
        w_wait_done = (r_state == S_WAIT) && cp_done;
        // the last ROM word still executes; only its completion is treated as a fault
        w_fault     = (r_state == S_WAIT) && (cp_done ? w_pc_last : w_expire);
        w_cnt_cmd   = CMD_W'(r_cnt);
        w_next      = r_state;
        case (r_state)
            S_IDLE:    w_next = start ? S_LOAD : S_IDLE;
            S_LOAD:    w_next = (w_load_acc && w_load_last) ? S_FETCH : S_LOAD;
            S_FETCH:   w_next = S_ISSUE;
            S_ISSUE:   w_next = w_halt ? S_READOUT : S_WAIT;
            S_WAIT:    w_next = w_fault ? S_FIN : (cp_done ? S_FETCH : S_WAIT);
            S_READOUT: w_next = w_out_last ? S_FIN : S_READOUT;
            S_FIN:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
            r_cmd   <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_pc    <= '0;
                r_cnt   <= '0;
                r_done  <= 1'b0;
                r_error <= 1'b0;
            end
            if (w_load_acc)
                r_cnt <= w_load_last ? '0 : r_cnt + 1'b1;
            if (r_state == S_READOUT)
                r_cnt <= w_out_last ? '0 : r_cnt + 1'b1;
            if (w_issue)
                r_cmd <= prog_data;
            if (w_wait_done && !w_pc_last)
                r_pc <= r_pc + 1'b1;
            if (w_fault)
                r_error <= 1'b1;
            if (w_next == S_FIN)
                r_done <= 1'b1;
        end
    end

    assign prog_addr  = r_pc;
    assign data_en    = w_load_acc;
    assign ins_in     = w_issue;
    assign get_output = r_state == S_READOUT;
    assign out_valid  = r_state == S_READOUT;
    assign command_cp = (r_state == S_LOAD || r_state == S_READOUT) ? w_cnt_cmd :
                        w_issue ? prog_data :
                        (r_state == S_WAIT) ? r_cmd : '0;
    assign busy       = !(r_state == S_IDLE || r_state == S_FIN);
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_cp_sequencer_1506.sv
// tb_cp_sequencer_1506: directed and randomized runs of the sequencer against
// a program-walking reference model, with a ROM and cp_done responder in the bench.
module tb_cp_sequencer_1506;
    import cp_pkg_1506::*;

    localparam int PC_W    = 4;
    localparam int N_LOAD  = 8;
    localparam int N_OUT   = 2;
    localparam int TIMEOUT = 15;
    localparam int PC_MAX  = (1 << PC_W) - 1;

    logic            clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0, cp_done = 1'b0;
    logic [PC_W-1:0] prog_addr;
    logic [23:0]     prog_data, command_cp;
    logic            ins_in, data_en, get_output, out_valid, busy, done, error;
    logic [23:0]     rom [PC_MAX+1];

    int n_tests = 0, n_fail = 0;
    int cyc = 0, lat_mode = 3, cd = 0;
    int first_ins_cyc, last_ins_cyc, last_load_cyc, done_cyc, halt_addr;
    int strobe_bad, cmd_bad;
    bit in_flight;
    logic [23:0] fl_cmd;
    logic [23:0] q_load [$];
    logic [27:0] q_ins [$];
    logic [23:0] q_out [$];

    always #5 clk = ~clk;
    always_ff @(posedge clk) prog_data <= rom[prog_addr];

    cp_sequencer_1506 #(.PC_W(PC_W), .N_LOAD(N_LOAD), .N_OUT(N_OUT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .prog_addr(prog_addr), .prog_data(prog_data), .command_cp(command_cp),
        .ins_in(ins_in), .data_en(data_en), .get_output(get_output),
        .cp_done(cp_done), .out_valid(out_valid), .busy(busy), .done(done), .error(error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: drive inputs just after the edge, sample settled outputs, respond to ins_in
    task automatic tick(input bit st, input bit iv, input bit cdv);
        @(posedge clk);
        #1;
        start = st;
        in_valid = iv;
        if (cd > 0) begin
            cd--;
            cp_done = (cd == 0);
        end else
            cp_done = cdv;
        #1;
        cyc++;
        if ($countones({ins_in, data_en, get_output}) > 1 || out_valid !== get_output)
            strobe_bad++;
        if (in_flight && busy && command_cp !== fl_cmd)
            cmd_bad++;
        if (data_en) begin
            q_load.push_back(command_cp);
            last_load_cyc = cyc;
        end
        if (ins_in) begin
            if (q_ins.size() == 0) first_ins_cyc = cyc;
            q_ins.push_back({prog_addr, command_cp});
            last_ins_cyc = cyc;
            in_flight = 1;
            fl_cmd = command_cp;
            cd = lat_mode > 0 ? lat_mode : (lat_mode == 0 ? int'($urandom_range(1, 8)) : 0);
        end else if (in_flight && (cp_done || !busy))
            in_flight = 0;
        if (get_output) begin
            if (q_out.size() == 0) halt_addr = prog_addr;
            q_out.push_back(command_cp);
        end
    endtask

    task automatic clear_mon();
        q_load.delete();
        q_ins.delete();
        q_out.delete();
        cd = 0;
        in_flight = 0;
        strobe_bad = 0;
        cmd_bad = 0;
        first_ins_cyc = 0;
        last_ins_cyc = 0;
        last_load_cyc = 0;
        halt_addr = -1;
    endtask

    // lm: fixed latency (>0), random (0) or never (-1); gm: 1 = alternating in_valid
    task automatic run(input int lm, input int gm, input bit noise, input string name);
        logic [27:0] e_ins [$];
        int pc = 0;
        bit halted = 0, err = 0, got = 0;
        clear_mon();
        lat_mode = lm;
        tick(1, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            bit iv, st, cdv;
            iv  = gm == 1 ? bit'(k % 2 == 0) : bit'($urandom_range(0, 1));
            st  = noise && ($urandom_range(0, 7) == 0);
            cdv = noise && (q_load.size() < N_LOAD) && ($urandom_range(0, 3) == 0);
            tick(st, iv, cdv);
            if (done && !busy) begin
                got = 1;
                done_cyc = cyc;
                break;
            end
        end
        chk({name, ":finished"}, got, 1);
        forever begin
            if (rom[pc][23:21] == 3'b111) begin
                halted = 1;
                break;
            end
            e_ins.push_back({4'(pc), rom[pc]});
            if (lm < 0 || pc == PC_MAX) begin
                err = 1;
                break;
            end
            pc++;
        end
        chk({name, ":n_load"}, q_load.size(), N_LOAD);
        for (int i = 0; i < q_load.size() && i < N_LOAD; i++)
            chk({name, ":load_addr"}, q_load[i], i);
        chk({name, ":n_ins"}, q_ins.size(), e_ins.size());
        for (int i = 0; i < q_ins.size() && i < e_ins.size(); i++)
            chk({name, ":ins_addr_cmd"}, q_ins[i], e_ins[i]);
        chk({name, ":n_out"}, q_out.size(), halted ? N_OUT : 0);
        for (int i = 0; i < q_out.size() && i < N_OUT; i++)
            chk({name, ":out_idx"}, q_out[i], i);
        if (halted)
            chk({name, ":halt_addr"}, halt_addr, pc);
        if (e_ins.size() > 0)
            chk({name, ":fetch_after_load"}, first_ins_cyc - last_load_cyc, 2);
        if (lm < 0 && e_ins.size() > 0)
            chk({name, ":timeout_cycles"}, done_cyc - last_ins_cyc, TIMEOUT + 1);
        chk({name, ":error"}, error, err);
        chk({name, ":strobes"}, strobe_bad, 0);
        chk({name, ":cmd_stable"}, cmd_bad, 0);
        tick(0, 0, 0);
        chk({name, ":idle_sticky"}, {busy, done, error}, {1'b0, 1'b1, err});
    endtask

    initial begin
        bit seen;
        for (int i = 0; i <= PC_MAX; i++) rom[i] = 24'hE00000;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {prog_addr, command_cp, ins_in, data_en, get_output, out_valid, busy, done, error}, 0);
        rst = 1;

        rom[0] = {INS_ADD, 21'h012345};
        rom[1] = {INS_MUL, 21'h0ABCDE};
        rom[2] = {INS_HALT, 21'h0};
        run(3, 1, 0, "add_mul_halt");

        run(-1, 0, 0, "timeout");

        rom[2] = {INS_SUB, 21'h1F0F0F};
        rom[3] = {INS_HALT, 21'h0};
        clear_mon();
        lat_mode = 3;
        seen = 0;
        tick(1, 0, 0);
        for (int k = 0; k < 500; k++) begin
            tick(0, 1, 0);
            if (q_ins.size() == 2) lat_mode = -1;
            if (q_ins.size() == 3) begin
                seen = 1;
                break;
            end
        end
        chk("rst_reach_wait", seen, 1);
        repeat (2) tick(0, 0, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_async_outputs", {prog_addr, command_cp, ins_in, data_en, get_output, out_valid, busy, done, error}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        cd = 0;
        tick(0, 0, 1);
        tick(0, 0, 0);
        chk("rst_late_cp_done", {busy, ins_in, command_cp, prog_addr}, 0);
        run(3, 0, 0, "rerun_after_rst");

        run(2, 0, 1, "noise_start_stray");

        for (int i = 0; i <= PC_MAX; i++) rom[i] = {3'($urandom_range(1, 4)), 21'($urandom)};
        run(0, 0, 0, "pc_overflow");

        for (int r = 0; r < 16; r++) begin
            int len = $urandom_range(0, 10);
            for (int i = 0; i <= PC_MAX; i++) rom[i] = {3'($urandom_range(0, 4)), 21'($urandom)};
            rom[len] = {INS_HALT, 21'($urandom)};
            run(0, 0, 1, "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cp_sequencer_1506.md
CP_SEQUENCER_1506 -- requirements
Module: cp_sequencer_1506

Interface
REQ-001 Parameter PC_W, default 10, width of program counter / program ROM address.
REQ-002 Parameter N_LOAD, default 8, number of operand words loaded before program execution.
REQ-003 Parameter N_OUT, default 2, number of result words read out after HALT.
REQ-004 Parameter TIMEOUT, default 4095, max cycles to wait for cp_done per instruction.
REQ-005 clk  in  1  single system clock, all flops rising-edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse, begins a run when IDLE.
REQ-008 in_valid  in  1  host operand word present on cryptoprocessor din_1/din_2 this cycle.
REQ-009 prog_addr  out  PC_W  program ROM address.
REQ-010 prog_data  in  24  program ROM word, valid one cycle after prog_addr.
REQ-011 command_cp  out  24  command to cryptoprocessor; [23:21] INS, [20:0] operand/address fields.
REQ-012 ins_in  out  1  instruction-execute strobe to cryptoprocessor.
REQ-013 data_en  out  1  operand-load strobe to cryptoprocessor.
REQ-014 get_output  out  1  result-read strobe to cryptoprocessor.
REQ-015 cp_done  in  1  instruction-complete pulse from cryptoprocessor memory unit.
REQ-016 out_valid  out  1  cryptoprocessor dout_1/dout_2 hold a result word this cycle.
REQ-017 busy / done / error  out  1 each  run active; run finished (sticky until start); timeout occurred (sticky until start).

Function
REQ-018 FSM states SHALL be IDLE, LOAD, FETCH, ISSUE, WAIT, READOUT, FIN.
REQ-019 IDLE: all strobes 0, command_cp 0; start SHALL clear done/error, pc=0, load_cnt=0, go to LOAD; start outside IDLE SHALL be ignored.
REQ-020 LOAD: data_en SHALL equal in_valid combinationally, ins_in=0, command_cp[20:0]=load_cnt (write address), [23:21]=0; load_cnt SHALL increment on each in_valid; after N_LOAD accepted words go to FETCH next cycle.
REQ-021 FETCH: prog_addr=pc, one wait cycle for ROM latency, then ISSUE.
REQ-022 ISSUE: if prog_data[23:21]==3'b111 (HALT) SHALL go to READOUT without strobing; else command_cp=prog_data registered, ins_in=1 for exactly one cycle, go to WAIT.
REQ-023 command_cp SHALL stay stable from ISSUE until cp_done is sampled.
REQ-024 WAIT: on cp_done, pc increments and FSM goes to FETCH; cp_done outside WAIT SHALL be ignored.
REQ-025 WAIT: watchdog counts from 0; reaching TIMEOUT without cp_done SHALL set error and go to FIN.
REQ-026 pc reaching 2^PC_W-1 without HALT SHALL execute that word, then set error and go to FIN (no wrap).
REQ-027 READOUT: get_output=1 and out_valid=1 for N_OUT consecutive cycles, command_cp[20:0]=result index 0..N_OUT-1, then FIN.
REQ-028 FIN: done=1, busy=0, one cycle, then IDLE; busy SHALL be 1 in all other non-IDLE states.
REQ-029 At most one of ins_in, data_en, get_output SHALL be 1 in any cycle.

Reset
REQ-030 rst low SHALL asynchronously force IDLE, pc/counters/watchdog 0, all outputs 0, including mid-run (in-flight cp_done afterwards ignored).

Structure
REQ-031 Shared package cp_pkg_1506 SHALL hold INS encodings (NOP 0, ADD 1, SUB 2, MUL 3, RED 4, HALT 7), the 24-bit command width and FSM state typedef.
REQ-032 Watchdog SHALL be a sub-module cp_watchdog (clear, enable, expire output).

Verification
REQ-033 N_LOAD=8, in_valid gapped (1,0,1,...) -> exactly 8 data_en pulses, addresses 0..7, FETCH entered after eighth.
REQ-034 Program ADD,MUL,HALT with cp_done 3 cycles after each ins_in -> two ins_in pulses, prog_addr 0,1,2, two get_output cycles, done pulse.
REQ-035 cp_done never returned, TIMEOUT=15 -> error=1 and done=1 after 15 WAIT cycles, no further ins_in.
REQ-036 rst low during WAIT -> outputs 0 same cycle asynchronously; later start re-runs from pc 0.
REQ-037 start pulsed while busy and stray cp_done in LOAD -> no state, pc or strobe change.
